// File: rtl/elc_alarm.sv
// Intrusion/lockout supervisor downstream of the lock controller: counts failed
// code attempts, raises a timed alarm, then a timed keypad lockout.
module elc_alarm #(
    parameter logic [2:0] max_errors  = 3'd3,
    parameter logic [5:0] alarm_len   = 6'd20,
    parameter logic [5:0] lockout_len = 6'd40
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       unlock,
    input  logic       error,
    input  logic       ack,
    output logic       alarm,
    output logic       lockout,
    output logic       tamper,
    output logic [2:0] err_count
);

    typedef enum logic [1:0] {IDLE, ALARM, LOCKOUT} state_t;

    // Zero-length intervals behave as one cycle.
    localparam logic [5:0] alarm_load   = (alarm_len   == 6'd0) ? 6'd0 : alarm_len   - 6'd1;
    localparam logic [5:0] lockout_load = (lockout_len == 6'd0) ? 6'd0 : lockout_len - 6'd1;

    state_t     state, state_nx;
    logic [5:0] timer, timer_nx;
    logic [2:0] cnt_nx;
    logic       tamper_nx;
    logic       unlock_d, error_d;
    logic       err_rise, unl_rise;

    assign err_rise = error  & ~error_d;
    assign unl_rise = unlock & ~unlock_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            err_count <= '0;
            tamper    <= 1'b0;
            unlock_d  <= 1'b0;
            error_d   <= 1'b0;
        end else begin
            state     <= state_nx;
            timer     <= timer_nx;
            err_count <= cnt_nx;
            tamper    <= tamper_nx;
            unlock_d  <= unlock;
            error_d   <= error;
        end
    end

    always_comb begin
        state_nx  = state;
        timer_nx  = timer;
        cnt_nx    = err_count;
        tamper_nx = tamper;
        case (state)
            IDLE: begin
                if (unl_rise)
                    cnt_nx = '0;
                else if (err_rise)
                    cnt_nx = err_count + 3'd1;
                if (cnt_nx == max_errors) begin
                    state_nx = ALARM;
                    timer_nx = alarm_load;
                end
                if (ack)
                    tamper_nx = 1'b0;
            end
            ALARM: begin
                if (unl_rise)
                    tamper_nx = 1'b1;
                if (ack || timer == 6'd0) begin
                    state_nx = LOCKOUT;
                    timer_nx = lockout_load;
                end else begin
                    timer_nx = timer - 6'd1;
                end
            end
            LOCKOUT: begin
                if (unl_rise)
                    tamper_nx = 1'b1;
                if (timer == 6'd0) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else begin
                    timer_nx = timer - 6'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign alarm   = (state == ALARM);
    assign lockout = (state != IDLE);

endmodule
